// File: rtl/memory_responder.sv
// Memory-side responder: latches a req/ack request, waits WAIT_CYCLES, does one word access.
// Define MEMORY_RESPONDER_ADDR_CHECK_EN to fault out-of-range addresses via err.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StWait = 3'b010,
    StAck  = 3'b100
  } state_e;

  state_e                state;
  logic [3:0]            cnt;
  logic                  we_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_idle;
  logic                  fire;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [IdxWidth-1:0]   idx;
  logic                  oob;

  // With zero wait states the access happens on the accepting edge, so use the live inputs.
  always_comb begin
    in_idle   = (state == StIdle);
    acc_we    = in_idle ? we    : we_l;
    acc_addr  = in_idle ? addr  : addr_l;
    acc_wdata = in_idle ? wdata : wdata_l;
    fire      = rst_n && ((in_idle && req && (WAIT_CYCLES == 0)) ||
                          ((state == StWait) && (cnt == 4'd0)));
  end

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  assign oob = (32'(acc_addr) >= DEPTH);
  assign idx = IdxWidth'(acc_addr);
`else
  assign oob = 1'b0;
  assign idx = IdxWidth'(32'(acc_addr) % DEPTH);
`endif

  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (fire && acc_we && !oob) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      ack     <= 1'b0;
      rdata   <= '0;
      cnt     <= 4'd0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req) begin
            we_l    <= we;
            addr_l  <= addr;
            wdata_l <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= StAck;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt == 4'd0) begin
            state <= StAck;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StAck: begin
          if (!req) begin
            state <= StIdle;
            ack   <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
      if (fire) begin
        ack <= 1'b1;
        if (!acc_we) begin
          rdata <= oob ? '1 : mem[idx];
        end
      end
    end
  end

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (fire) begin
      err_q <= oob;
    end else if ((state == StAck) && !req) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (WAIT_CYCLES 1/0/3), vector table,
// corner-case sequences and random traffic against an array model.
module tb_memory_responder;

  localparam int N = 3;

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n [N];
  logic        req   [N];
  logic        we    [N];
  logic [7:0]  addr  [N];
  logic [31:0] wdata [N];
  logic        ack   [N];
  logic [31:0] rdata [N];
  logic        busy  [N];
  logic        err   [N];

  always #5 clk = ~clk;

  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));

  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));

  memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(128), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]), .err(err[2]));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] mdl   [N][256];
  bit          known [N][256];

  function automatic int wc(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int depth(int i);
    return (i == 2) ? 128 : 256;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full handshake; inputs are scrambled after the accepting edge to prove latching.
  task automatic xact(int i, bit w, logic [7:0] a, logic [31:0] d, logic [31:0] exp_rd,
                      bit exp_err, string tag);
    int n;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    n = 0;
    tick();
    n++;
    check($sformatf("%s busy_after_accept", tag), 32'(busy[i]), 32'd1);
    addr[i] = ~a;
    wdata[i] = ~d;
    while (!ack[i] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s latency", tag), 32'(n), 32'(wc(i) + 1));
    if (!w) check($sformatf("%s rdata", tag), rdata[i], exp_rd);
    check($sformatf("%s err", tag), 32'(err[i]), 32'(exp_err));
    req[i] = 1'b0;
    tick();
    check($sformatf("%s ack_fall", tag), 32'(ack[i]), 32'd0);
    check($sformatf("%s busy_fall", tag), 32'(busy[i]), 32'd0);
    check($sformatf("%s err_fall", tag), 32'(err[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    vecs[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 8'h05, 32'h00000123, 32'h0, 1'b0};
    vecs[3]  = '{1, 1'b0, 8'h05, 32'h0, 32'h00000123, 1'b0};
    vecs[4]  = '{2, 1'b1, 8'h40, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[5]  = '{2, 1'b1, 8'hC0, 32'h12345678, 32'h0, Chk};
    vecs[6]  = '{2, 1'b0, 8'h40, 32'h0, Chk ? 32'hA5A5A5A5 : 32'h12345678, 1'b0};
    vecs[7]  = '{2, 1'b0, 8'hC0, 32'h0, Chk ? 32'hFFFFFFFF : 32'h12345678, Chk};
    vecs[8]  = '{0, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[9]  = '{0, 1'b0, 8'hFF, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{2, 1'b1, 8'h7F, 32'h00000001, 32'h0, 1'b0};
    vecs[11] = '{2, 1'b0, 8'h7F, 32'h0, 32'h00000001, 1'b0};

    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end

    // Reset then idle
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        check($sformatf("reset ack%0d", i), 32'(ack[i]), 32'd0);
        check($sformatf("reset busy%0d", i), 32'(busy[i]), 32'd0);
        check($sformatf("reset rdata%0d", i), rdata[i], 32'd0);
        check($sformatf("reset err%0d", i), 32'(err[i]), 32'd0);
      end
    end
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) check($sformatf("idle ack%0d", i), 32'(ack[i]), 32'd0);

    for (int v = 0; v < 12; v++) begin
      xact(vecs[v].inst, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].exp_rd, vecs[v].exp_err,
           $sformatf("vec%0d", v));
    end

    // Zero wait states: hold req and require a stable ack/rdata
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h05;
    tick();
    check("w0 ack", 32'(ack[1]), 32'd1);
    check("w0 rdata", rdata[1], 32'h00000123);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("w0 hold ack%0d", c), 32'(ack[1]), 32'd1);
      check($sformatf("w0 hold rdata%0d", c), rdata[1], 32'h00000123);
    end
    req[1] = 1'b0;
    tick();
    check("w0 ack_fall", 32'(ack[1]), 32'd0);

    // Early req drop during WAIT: access completes, ack high one cycle
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h20; wdata[2] = 32'h55AA55AA;
    tick();
    req[2] = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack[2]) hi_cnt++;
    end
    check("early_drop ack_cycles", 32'(hi_cnt), 32'd1);
    check("early_drop busy", 32'(busy[2]), 32'd0);
    xact(2, 1'b0, 8'h20, 32'h0, 32'h55AA55AA, 1'b0, "early_drop_read");

    // Reset in second WAIT cycle aborts the write
    xact(2, 1'b1, 8'h30, 32'h0, 32'h0, 1'b0, "pre30");
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h30; wdata[2] = 32'h1;
    tick();
    tick();
    rst_n[2] = 1'b0;
    req[2] = 1'b0;
    #1;
    check("rst_wait ack", 32'(ack[2]), 32'd0);
    check("rst_wait busy", 32'(busy[2]), 32'd0);
    tick();
    rst_n[2] = 1'b1;
    tick();
    xact(2, 1'b0, 8'h30, 32'h0, 32'h0, 1'b0, "rst_wait_read");

    // Reset in ACK keeps the completed write
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h31; wdata[2] = 32'h00000077;
    for (int c = 0; c < 20 && !ack[2]; c++) tick();
    check("rst_ack ack_seen", 32'(ack[2]), 32'd1);
    rst_n[2] = 1'b0;
    req[2] = 1'b0;
    #1;
    check("rst_ack ack", 32'(ack[2]), 32'd0);
    tick();
    rst_n[2] = 1'b1;
    tick();
    xact(2, 1'b0, 8'h31, 32'h0, 32'h00000077, 1'b0, "rst_ack_read");

    // Random traffic against the array model
    for (int k = 0; k < 80; k++) begin
      int          i;
      int          idx;
      bit          w;
      bit          oob;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
      i   = $urandom_range(0, N - 1);
      a   = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))};
      d   = $urandom;
      w   = 1'($urandom_range(0, 1));
      oob = Chk && (int'(a) >= depth(i));
      idx = int'(a) % depth(i);
      if (!w && !oob && !known[i][idx]) w = 1'b1;
      exp = 32'h0;
      if (oob) begin
        exp = 32'hFFFFFFFF;
      end else if (w) begin
        mdl[i][idx]   = d;
        known[i][idx] = 1'b1;
      end else begin
        exp = mdl[i][idx];
      end
      xact(i, w, a, d, exp, oob, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
